irq_controller: RTL and testbench

Parametrised interrupt controller for the 6502 system bus. It replaces the single hard-wired set/clear IRQ byte with N synchronised sources, each with its own enable, polarity and edge/level mode. It also adds software-forced interrupts and a priority vector register. It sits on the CPU data bus behind one address-decoder chip select and drives the CPU's active-low IRQ line.

---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_src_sync.sv | 30 +++
 rtl/irq_controller.sv | 137 +++++++++++++
 tb/tb_irq_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Register map and shared constants for the 6502 bus interrupt controller.
package irq_pkg;

  localparam logic [3:0] PEND_L  = 4'h0;
  localparam logic [3:0] PEND_H  = 4'h1;
  localparam logic [3:0] EN_L    = 4'h2;
  localparam logic [3:0] EN_H    = 4'h3;
  localparam logic [3:0] MODE_L  = 4'h4;
  localparam logic [3:0] MODE_H  = 4'h5;
  localparam logic [3:0] POL_L   = 4'h6;
  localparam logic [3:0] POL_H   = 4'h7;
  localparam logic [3:0] VEC     = 4'h8;
  localparam logic [3:0] FORCE_L = 4'hA;
  localparam logic [3:0] FORCE_H = 4'hB;

  // VEC bit flagging "no enabled source pending".
  localparam int unsigned VEC_NONE = 7;

endpackage

// File: rtl/irq_src_sync.sv
// Per-source synchroniser, history flop, polarity correction and active-edge detect.
module irq_src_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic pol,
  output logic act,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both samples use the current polarity, so a polarity change alone never looks like an edge.
  assign act        = sync_q[SYNC_STAGES-1] ^ pol;
  assign edge_pulse = act & ~(hist_q ^ pol);

endmodule

// File: rtl/irq_controller.sv
// N-source interrupt controller: register file, pending logic and priority vector
// behind one chip select, driving the CPU's active-low IRQ line.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             rw,
  input  logic [3:0]       addr,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  input  logic [N_SRC-1:0] src,
  output logic             irqb
);

  logic [N_SRC-1:0] pend_q, en_q, mode_q, pol_q;
  logic [N_SRC-1:0] pend_d, en_d, mode_d, pol_d;
  logic [N_SRC-1:0] act, edge_det;
  logic [N_SRC-1:0] lane, wbits, chg, w1c, frc, pe;
  logic             wr, wr_pend, wr_en, wr_mode, wr_pol, wr_force;
  logic [7:0]       vec_r;
  logic [15:0]      pend16, en16, mode16, pol16;
  logic             found;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    irq_src_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk        (clk),
      .rst        (rst),
      .src        (src[i]),
      .pol        (pol_q[i]),
      .act        (act[i]),
      .edge_pulse (edge_det[i])
    );
  end

  assign wr       = cs & ~rw;
  assign wr_pend  = wr && (addr == PEND_L  || addr == PEND_H);
  assign wr_en    = wr && (addr == EN_L    || addr == EN_H);
  assign wr_mode  = wr && (addr == MODE_L  || addr == MODE_H);
  assign wr_pol   = wr && (addr == POL_L   || addr == POL_H);
  assign wr_force = wr && (addr == FORCE_L || addr == FORCE_H);

  // addr[0] picks the byte lane; lanes beyond N_SRC simply have no bits to hit.
  always_comb begin
    lane  = '0;
    wbits = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      lane[i]  = (i >= 8) ? addr[0] : ~addr[0];
      wbits[i] = lane[i] & data_in[i % 8];
    end
  end

  assign en_d   = wr_en   ? ((en_q   & ~lane) | wbits) : en_q;
  assign mode_d = wr_mode ? ((mode_q & ~lane) | wbits) : mode_q;
  assign pol_d  = wr_pol  ? ((pol_q  & ~lane) | wbits) : pol_q;
  assign chg    = (mode_d ^ mode_q) | (pol_d ^ pol_q);
  assign w1c    = wr_pend  ? wbits : '0;
  assign frc    = wr_force ? wbits : '0;

  // A MODE/POL change on a bit dominates everything else for that cycle.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (chg[i])
        pend_d[i] = 1'b0;
      else if (mode_q[i]) begin
        if (edge_det[i] || frc[i])
          pend_d[i] = 1'b1;
        else if (w1c[i])
          pend_d[i] = 1'b0;
      end else
        pend_d[i] = act[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      irqb   <= 1'b1;
    end else begin
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      pol_q  <= pol_d;
      irqb   <= ~|(pend_q & en_q);
    end
  end

  assign pe = pend_q & en_q;

  always_comb begin
    vec_r           = '0;
    vec_r[VEC_NONE] = 1'b1;
    found           = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (pe[i] && !found) begin
        found = 1'b1;
        vec_r = {4'h0, i[3:0]};
      end
    end
  end

  always_comb begin
    pend16 = '0;
    en16   = '0;
    mode16 = '0;
    pol16  = '0;
    pend16[N_SRC-1:0] = pend_q;
    en16[N_SRC-1:0]   = en_q;
    mode16[N_SRC-1:0] = mode_q;
    pol16[N_SRC-1:0]  = pol_q;
  end

  always_comb begin
    data_out = 8'h00;
    case (addr)
      PEND_L:  data_out = pend16[7:0];
      PEND_H:  data_out = pend16[15:8];
      EN_L:    data_out = en16[7:0];
      EN_H:    data_out = en16[15:8];
      MODE_L:  data_out = mode16[7:0];
      MODE_H:  data_out = mode16[15:8];
      POL_L:   data_out = pol16[7:0];
      POL_H:   data_out = pol16[15:8];
      VEC:     data_out = vec_r;
      default: data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with 12 sources: register table plus timing sequences.
module tb_irq_controller;
  import irq_pkg::*;

  localparam int unsigned NS = 12;

  logic          clk = 1'b0;
  logic          rst, cs, rw;
  logic [3:0]    addr;
  logic [7:0]    data_in, data_out;
  logic [NS-1:0] src;
  logic          irqb;

  int checks = 0;
  int errors = 0;

  irq_controller #(.N_SRC(NS), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .rw       (rw),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .src      (src),
    .irqb     (irqb)
  );

  always #50 clk = ~clk;

  typedef struct {
    bit         wr;
    logic [3:0] a;
    logic [7:0] d;
    bit         ci;
    bit         irq;
  } op_t;

  op_t ops[$];

  function automatic op_t mk(bit w, logic [3:0] a, logic [7:0] d, bit ci, bit irq);
    op_t o;
    o.wr = w; o.a = a; o.d = d; o.ci = ci; o.irq = irq;
    return o;
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; data_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp, input string nm);
    cs = 1'b1; rw = 1'b1; addr = a;
    #1;
    check(nm, data_out, exp);
    cs = 1'b0;
  endtask

  task automatic irq_chk(input logic exp, input string nm);
    check(nm, {7'b0, irqb}, {7'b0, exp});
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cs = 1'b0; rw = 1'b1; addr = '0; data_in = '0; src = '0;
    tick(3);
    rst = 1'b0;

    // reset state of every address
    for (int a = 0; a < 16; a++)
      ops.push_back(mk(0, a[3:0], (a == 8) ? 8'h80 : 8'h00, 1, 1));
    ops.push_back(mk(1, FORCE_L, 8'h01, 0, 0));  // level mode: ignored
    ops.push_back(mk(0, PEND_L,  8'h00, 0, 0));
    ops.push_back(mk(1, EN_L,    8'hFF, 0, 0));
    ops.push_back(mk(1, EN_H,    8'hFF, 0, 0));
    ops.push_back(mk(0, EN_H,    8'h0F, 0, 0));  // bits 15:12 absent
    ops.push_back(mk(1, MODE_L,  8'hFF, 0, 0));
    ops.push_back(mk(1, MODE_H,  8'h0F, 0, 0));
    ops.push_back(mk(0, MODE_H,  8'h0F, 0, 0));
    ops.push_back(mk(1, FORCE_H, 8'h08, 0, 0));
    ops.push_back(mk(1, FORCE_L, 8'h20, 0, 0));
    ops.push_back(mk(0, VEC,     8'h05, 1, 0));
    ops.push_back(mk(0, PEND_L,  8'h20, 0, 0));
    ops.push_back(mk(0, PEND_H,  8'h08, 0, 0));
    ops.push_back(mk(0, FORCE_L, 8'h00, 0, 0));
    ops.push_back(mk(1, PEND_L,  8'h20, 0, 0));
    ops.push_back(mk(0, VEC,     8'h0B, 1, 0));
    ops.push_back(mk(1, PEND_H,  8'h08, 0, 0));
    ops.push_back(mk(0, VEC,     8'h80, 0, 0));
    ops.push_back(mk(1, MODE_L,  8'h00, 0, 0));
    ops.push_back(mk(1, MODE_H,  8'h00, 0, 0));
    ops.push_back(mk(1, EN_L,    8'h00, 0, 0));
    ops.push_back(mk(1, EN_H,    8'h00, 0, 0));
    ops.push_back(mk(0, PEND_L,  8'h00, 1, 1));

    foreach (ops[i]) begin
      if (ops[i].wr)
        wr_reg(ops[i].a, ops[i].d);
      else begin
        rd_chk(ops[i].a, ops[i].d, $sformatf("tbl%0d_rd_%h", i, ops[i].a));
        if (ops[i].ci)
          irq_chk(ops[i].irq, $sformatf("tbl%0d_irqb", i));
      end
    end

    // edge-mode latency on src[0], then W1C release
    wr_reg(EN_L, 8'h01);
    wr_reg(MODE_L, 8'h01);
    src[0] = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick(1);
      irq_chk((n == 4) ? 1'b0 : 1'b1, $sformatf("edge_lat_irqb_e%0d", n));
      if (n == 2) rd_chk(PEND_L, 8'h00, "edge_lat_pend_e2");
      if (n == 3) rd_chk(PEND_L, 8'h01, "edge_lat_pend_e3");
    end
    rd_chk(VEC, 8'h00, "edge_vec");
    src[0] = 1'b0;
    wr_reg(PEND_L, 8'h01);
    irq_chk(1'b0, "w1c_irqb_same_edge");
    rd_chk(PEND_L, 8'h00, "w1c_pend");
    tick(1);
    irq_chk(1'b1, "w1c_irqb_next_edge");
    wr_reg(MODE_L, 8'h00);
    wr_reg(EN_L, 8'h00);
    tick(3);

    // level mode, active-low src[1]
    wr_reg(POL_L, 8'h02);
    wr_reg(MODE_L, 8'h00);
    wr_reg(EN_L, 8'h02);
    tick(4);
    rd_chk(PEND_L, 8'h02, "lvl_pend_active");
    irq_chk(1'b0, "lvl_irqb_active");
    wr_reg(PEND_L, 8'h02);
    rd_chk(PEND_L, 8'h02, "lvl_w1c_ignored");
    src[1] = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick(1);
      irq_chk((n == 4) ? 1'b1 : 1'b0, $sformatf("lvl_release_irqb_e%0d", n));
      if (n == 3) rd_chk(PEND_L, 8'h00, "lvl_release_pend_e3");
    end
    src[1] = 1'b0;
    tick(4);
    wr_reg(POL_L, 8'h00);
    wr_reg(EN_L, 8'h00);
    tick(3);
    rd_chk(PEND_L, 8'h00, "lvl_cleanup_pend");

    // edge on src[0] coincides with W1C of bit 0: set wins
    wr_reg(EN_L, 8'h01);
    wr_reg(MODE_L, 8'h01);
    src[0] = 1'b1;
    tick(2);
    wr_reg(PEND_L, 8'h01);
    rd_chk(PEND_L, 8'h01, "set_beats_w1c");
    wr_reg(PEND_L, 8'h01);
    rd_chk(PEND_L, 8'h00, "w1c_after_collision");
    src[0] = 1'b0;
    wr_reg(MODE_L, 8'h00);
    wr_reg(EN_L, 8'h00);
    tick(3);

    // src[2] held active through a mid-run reset
    wr_reg(EN_L, 8'hFF);
    src[2] = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    irq_chk(1'b1, "rst_irqb");
    rd_chk(EN_L, 8'h00, "rst_en");
    rd_chk(PEND_L, 8'h00, "rst_pend");
    tick(4);
    rd_chk(PEND_L, 8'h04, "rst_level_repend");
    wr_reg(MODE_L, 8'h04);
    rd_chk(PEND_L, 8'h00, "mode_chg_clears");
    tick(3);
    rd_chk(PEND_L, 8'h00, "held_no_edge");
    wr_reg(POL_L, 8'h04);
    tick(2);
    rd_chk(PEND_L, 8'h00, "pol_to_low_no_edge");
    wr_reg(POL_L, 8'h00);
    tick(2);
    rd_chk(PEND_L, 8'h00, "pol_to_high_no_edge");
    rd_chk(VEC, 8'h80, "final_vec");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
